// File: rtl/cpu_trace_monitor.sv
// Write-back stage observer: per-run performance counters plus a
// ready/valid trace FIFO of retired instructions. A run ends with a fixed
// drain window after end_program, after which all results freeze.
module cpu_trace_monitor #(
  parameter int XLEN         = 64,
  parameter int PC_W         = 32,
  parameter int COUNT_W      = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        wb_valid,
  input  logic [PC_W-1:0]             wb_pc,
  input  logic [31:0]                 wb_instruction,
  input  logic                        wb_reg_write,
  input  logic [4:0]                  wb_rd,
  input  logic [XLEN-1:0]             wb_data,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        end_program,
  output logic [1:0]                  state,
  output logic                        done,
  output logic [COUNT_W-1:0]          cycle_count,
  output logic [COUNT_W-1:0]          instret_count,
  output logic [COUNT_W-1:0]          stall_count,
  output logic [COUNT_W-1:0]          flush_count,
  output logic                        trace_valid,
  input  logic                        trace_ready,
  output logic [PC_W+32+5+XLEN-1:0]   trace_data,
  output logic                        trace_overflow
);

  localparam int TW = PC_W + 32 + 5 + XLEN;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [COUNT_W-1:0]   cycle_q, cycle_d;
  logic [COUNT_W-1:0]   instret_q, instret_d;
  logic [COUNT_W-1:0]   stall_q, stall_d;
  logic [COUNT_W-1:0]   flush_q, flush_d;
  logic [TW-1:0]        mem_q [FIFO_DEPTH];
  logic [TW-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]        occ_q, occ_d;
  logic                 overflow_q, overflow_d;

  logic                 active;
  logic                 retire;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic [TW-1:0]        record;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

  // Decode of the current cycle's events and the record that would be captured
  always_comb begin
    active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    retire    = wb_valid && (wb_instruction != '0);
    fifo_full = (occ_q == OW'(FIFO_DEPTH));
    pop       = (occ_q != '0) && trace_ready;
    if (wb_reg_write && (wb_rd != '0))
      record = {wb_pc, wb_instruction, wb_rd, wb_data};
    else
      record = {wb_pc, wb_instruction, 5'd0, {XLEN{1'b0}}};
  end

  // Next-state for FSM, counters and FIFO; start overrides everything, so a
  // restart discards that cycle's events and any pop on the same edge
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    cycle_d     = cycle_q;
    instret_d   = instret_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    overflow_d  = overflow_q;
    push        = 1'b0;

    if (start) begin
      state_d     = S_RUN;
      drain_cnt_d = '0;
      cycle_d     = '0;
      instret_d   = '0;
      stall_d     = '0;
      flush_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      overflow_d  = 1'b0;
    end else begin
      if (active) begin
        cycle_d = sat_inc(cycle_q);
        if (stall) stall_d = sat_inc(stall_q);
        if (flush) flush_d = sat_inc(flush_q);
        if (retire) begin
          instret_d = sat_inc(instret_q);
          if (!fifo_full || pop) push = 1'b1;
          else                   overflow_d = 1'b1;
        end
      end

      if (push) begin
        mem_d[wr_ptr_q] = record;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

      if (push && !pop)      occ_d = occ_q + OW'(1);
      else if (!push && pop) occ_d = occ_q - OW'(1);

      case (state_q)
        S_RUN: begin
          if (end_program) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DW'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) state_d = S_DONE;
          else                   drain_cnt_d = drain_cnt_q - DW'(1);
        end
        default: ;
      endcase
    end
  end

  // State, counter and FIFO registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
      stall_q     <= '0;
      flush_q     <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      overflow_q  <= overflow_d;
    end
  end

  assign state          = state_q;
  assign done           = (state_q == S_DONE);
  assign cycle_count    = cycle_q;
  assign instret_count  = instret_q;
  assign stall_count    = stall_q;
  assign flush_count    = flush_q;
  assign trace_valid    = (occ_q != '0);
  assign trace_data     = trace_valid ? mem_q[rd_ptr_q] : '0;
  assign trace_overflow = overflow_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor with hand-computed expectations.
module tb_cpu_trace_monitor;

  localparam int XLEN    = 64;
  localparam int PC_W    = 32;
  localparam int COUNT_W = 32;
  localparam int TW      = PC_W + 32 + 5 + XLEN;

  logic               clk;
  logic               reset;
  logic               start;
  logic               wb_valid;
  logic [PC_W-1:0]    wb_pc;
  logic [31:0]        wb_instruction;
  logic               wb_reg_write;
  logic [4:0]         wb_rd;
  logic [XLEN-1:0]    wb_data;
  logic               stall;
  logic               flush;
  logic               end_program;
  logic [1:0]         state;
  logic               done;
  logic [COUNT_W-1:0] cycle_count;
  logic [COUNT_W-1:0] instret_count;
  logic [COUNT_W-1:0] stall_count;
  logic [COUNT_W-1:0] flush_count;
  logic               trace_valid;
  logic               trace_ready;
  logic [TW-1:0]      trace_data;
  logic               trace_overflow;

  int n_cmp;
  int n_err;

  cpu_trace_monitor #(
    .XLEN(XLEN), .PC_W(PC_W), .COUNT_W(COUNT_W), .FIFO_DEPTH(8), .DRAIN_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instruction(wb_instruction),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .flush(flush), .end_program(end_program),
    .state(state), .done(done),
    .cycle_count(cycle_count), .instret_count(instret_count),
    .stall_count(stall_count), .flush_count(flush_count),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_data(trace_data), .trace_overflow(trace_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] mk_rec(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic rw, input logic [4:0] rd,
                                           input logic [63:0] d);
    if (rw && rd != 5'd0) return {pc, ins, rd, d};
    return {pc, ins, 5'd0, 64'd0};
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic rw,
                       input logic [4:0] rd, input logic [63:0] d);
    wb_valid = 1'b1; wb_pc = pc; wb_instruction = ins;
    wb_reg_write = rw; wb_rd = rd; wb_data = d;
  endtask

  task automatic idle_wb();
    wb_valid = 1'b0; wb_pc = '0; wb_instruction = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  // Generated retirement stream i: rec 3 does not write, rec 5 targets x0
  function automatic logic [31:0] g_pc(input int i);  return 32'h1000 + 32'(4 * i); endfunction
  function automatic logic [31:0] g_ins(input int i); return 32'h0000_0013 | (32'(i + 1) << 20); endfunction
  function automatic logic        g_rw(input int i);  return (i != 3); endfunction
  function automatic logic [4:0]  g_rd(input int i);  return (i == 5) ? 5'd0 : 5'(i + 1); endfunction
  function automatic logic [63:0] g_d(input int i);   return 64'hA000_0000_0000_0000 + 64'(i); endfunction

  task automatic drive_g(input int i);
    drive(g_pc(i), g_ins(i), g_rw(i), g_rd(i), g_d(i));
  endtask

  function automatic logic [TW-1:0] exp_g(input int i);
    return mk_rec(g_pc(i), g_ins(i), g_rw(i), g_rd(i), g_d(i));
  endfunction

  logic [31:0] p_ins  [3];
  logic [4:0]  p_rd   [3];
  logic [63:0] p_data [3];

  initial begin
    n_cmp = 0; n_err = 0;
    p_ins  = '{32'h0030_0093, 32'h0070_0113, 32'h0011_0133};
    p_rd   = '{5'd1, 5'd2, 5'd2};
    p_data = '{64'd3, 64'd7, 64'd10};

    reset = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
    end_program = 1'b0; trace_ready = 1'b0;
    idle_wb();
    tick(); tick();
    check("rst_state", state, 2'b00);
    check("rst_done", done, 1'b0);
    check("rst_cycle", cycle_count, 0);
    check("rst_instret", instret_count, 0);
    check("rst_tvalid", trace_valid, 1'b0);
    check("rst_tdata", trace_data, 0);
    check("rst_ovf", trace_overflow, 1'b0);

    // Idle with retiring instructions visible: nothing counted
    reset = 1'b1;
    drive(32'h40, 32'h0000_0013, 1'b1, 5'd3, 64'd1);
    stall = 1'b1; flush = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("idle_state", state, 2'b00);
    check("idle_cycle", cycle_count, 0);
    check("idle_instret", instret_count, 0);
    check("idle_stall", stall_count, 0);
    check("idle_tvalid", trace_valid, 1'b0);
    stall = 1'b0; flush = 1'b0; idle_wb();

    // Program run: 12 RUN cycles, retirements on cycles 3..5
    start = 1'b1; tick(); start = 1'b0;
    check("run_state", state, 2'b01);
    check("run_cycle0", cycle_count, 0);
    for (int c = 1; c <= 12; c++) begin
      idle_wb();
      if (c >= 3 && c <= 5)
        drive(32'(4 * (c - 1)), p_ins[c-3], 1'b1, p_rd[c-3], p_data[c-3]);
      end_program = (c == 12);
      tick();
    end
    end_program = 1'b0; idle_wb();
    check("drain_state", state, 2'b10);
    check("drain_cycle", cycle_count, 12);
    check("drain_instret", instret_count, 3);
    for (int i = 0; i < 4; i++) tick();
    check("drain_still", state, 2'b10);
    check("drain_done_low", done, 1'b0);
    tick();
    check("done_state", state, 2'b11);
    check("done_flag", done, 1'b1);
    check("done_cycle", cycle_count, 17);
    check("done_instret", instret_count, 3);

    // Frozen after DONE
    drive(32'h80, 32'h0000_0013, 1'b1, 5'd4, 64'd9);
    stall = 1'b1; end_program = 1'b1;
    tick(); tick();
    stall = 1'b0; end_program = 1'b0; idle_wb();
    check("frz_cycle", cycle_count, 17);
    check("frz_instret", instret_count, 3);
    check("frz_stall", stall_count, 0);
    check("frz_state", state, 2'b11);

    // Drain the three records in order
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("p_tvalid", trace_valid, 1'b1);
      check("p_rec", trace_data, mk_rec(32'(4 * (i + 2)), p_ins[i], 1'b1, p_rd[i], p_data[i]));
      tick();
    end
    check("p_empty", trace_valid, 1'b0);
    check("p_tdata0", trace_data, 0);
    trace_ready = 1'b0;

    // Stall/flush counting: both high in the first cycle
    start = 1'b1; tick(); start = 1'b0;
    check("sf_state", state, 2'b01);
    check("sf_clr", cycle_count, 0);
    stall = 1'b1; flush = 1'b1; tick();
    stall = 1'b1; flush = 1'b0; tick();
    stall = 1'b0; flush = 1'b1; tick();
    stall = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    check("sf_stall", stall_count, 2);
    check("sf_flush", flush_count, 3);
    check("sf_cycle", cycle_count, 4);

    // Restart while in RUN, then fill the FIFO exactly
    stall = 1'b1;
    start = 1'b1; tick(); start = 1'b0; stall = 1'b0;
    check("rs_cycle", cycle_count, 0);
    check("rs_stall", stall_count, 0);
    check("rs_flush", flush_count, 0);
    drive(32'h44, 32'h0, 1'b1, 5'd1, 64'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive_g(i);
      tick();
    end
    idle_wb();
    check("full_instret", instret_count, 8);
    check("full_cycle", cycle_count, 9);
    check("full_ovf", trace_overflow, 1'b0);
    check("full_head", trace_data, exp_g(0));

    // Push and pop on the same edge while full
    drive_g(8); trace_ready = 1'b1; tick();
    trace_ready = 1'b0; idle_wb();
    check("pp_ovf", trace_overflow, 1'b0);
    check("pp_head", trace_data, exp_g(1));
    check("pp_instret", instret_count, 9);

    // Two more retirements while full: dropped
    drive_g(9);  tick();
    drive_g(10); tick();
    idle_wb();
    check("ov_flag", trace_overflow, 1'b1);
    check("ov_instret", instret_count, 11);
    check("ov_hold", trace_data, exp_g(1));
    tick();
    check("ov_hold2", trace_data, exp_g(1));

    trace_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("ov_tvalid", trace_valid, 1'b1);
      check("ov_rec", trace_data, exp_g(i));
      tick();
    end
    check("ov_empty", trace_valid, 1'b0);
    trace_ready = 1'b0;

    // Async reset in the middle of DRAIN
    end_program = 1'b1; tick(); end_program = 1'b0;
    check("ar_drain", state, 2'b10);
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("ar_state", state, 2'b00);
    check("ar_cycle", cycle_count, 0);
    check("ar_instret", instret_count, 0);
    check("ar_ovf", trace_overflow, 1'b0);
    check("ar_tvalid", trace_valid, 1'b0);
    reset = 1'b1;
    tick();
    check("ar_idle", state, 2'b00);

    // Run to DONE with overflow set, then restart from DONE
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_g(i);
      tick();
    end
    idle_wb();
    end_program = 1'b1; tick(); end_program = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("d2_done", done, 1'b1);
    check("d2_ovf", trace_overflow, 1'b1);
    check("d2_instret", instret_count, 9);
    check("d2_cycle", cycle_count, 15);
    start = 1'b1; tick(); start = 1'b0;
    check("rd_state", state, 2'b01);
    check("rd_done", done, 1'b0);
    check("rd_ovf", trace_overflow, 1'b0);
    check("rd_cycle", cycle_count, 0);
    check("rd_instret", instret_count, 0);
    check("rd_tvalid", trace_valid, 1'b0);
    stall = 1'b1;
    tick(); tick(); tick();
    stall = 1'b0;
    check("rd_cycle3", cycle_count, 3);
    check("rd_stall3", stall_count, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
